muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameters, one per line:
- ITER, 32, number of iteration cycles for multiply/divide
- MULTU, 6'b011001, funct code for unsigned multiply
- DIVU, 6'b011011, funct code for unsigned divide
- MFHI, 6'b010000, funct code for move-from-HI
- MFLO, 6'b010010, funct code for move-from-LO
REQ-002 One clock; reset is synchronous and active-high. Ports, one per line:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Start  in  1  instruction issue strobe
- Funct  in  6  funct field, valid when Start=1
- DivZero  in  1  divisor-is-zero flag, sampled in LOAD
- Abort  in  1  pipeline flush
- Busy  out  1  unit occupied (state != IDLE)
- Load  out  1  latch operands into multiplier/divider
- Step  out  1  advance one iteration
- OpDiv  out  1  1 = divide, 0 = multiply; held for the whole operation
- HiLoWrite  out  1  write result into HI/LO
- Done  out  1  operation-complete pulse
- DZ  out  1  divide-by-zero status
- Stall  out  1  hold the issuing stage
- Count  out  6  iteration index

Function
REQ-003 The FSM SHALL have 4 states (IDLE, LOAD, RUN, WRITE), and all state transitions SHALL occur on the rising edge of clk.
REQ-004 In IDLE, when Start=1 and Funct is MULTU or DIVU, the FSM SHALL go to LOAD, capture OpDiv (1 iff DIVU), and set Count=0; any other Funct SHALL be ignored.
REQ-005 Load SHALL be 1 only in LOAD, for exactly 1 cycle.
REQ-006 From LOAD, the FSM SHALL go to RUN, except when OpDiv=1 and DivZero=1: then it SHALL go directly to WRITE and set DZ=1.
REQ-007 In RUN, Step SHALL be 1 every cycle and Count SHALL increment by 1 per cycle from 0.
REQ-008 The FSM SHALL leave RUN for WRITE in the cycle after Count=ITER-1, so Step is high for exactly ITER cycles.
REQ-009 Count SHALL hold its value outside RUN and SHALL never wrap within an operation.
REQ-010 In WRITE, HiLoWrite and Done SHALL both be 1 for exactly 1 cycle, and the FSM SHALL then return to IDLE.
REQ-011 Latency: for a Start accepted at edge N, HiLoWrite SHALL be high in cycle N+ITER+2, and Busy SHALL be high for ITER+2 cycles.
REQ-012 DZ SHALL be cleared when the next operation is accepted, and SHALL otherwise hold its value.
REQ-013 Stall SHALL be combinational and equal to Start AND Busy AND Funct in {MULTU, DIVU, MFHI, MFLO}.
REQ-014 Stall SHALL remain 1 during WRITE, because HI/LO is not yet updated in that cycle.
REQ-015 When Start=1 with MFHI/MFLO while in IDLE, Stall SHALL be 0, and no state change SHALL occur.
REQ-016 When Start=1 while Busy=1, the request SHALL NOT be queued; the issuer SHALL re-present it after Stall drops.
REQ-017 When Abort=1 in any state, the FSM SHALL go to IDLE at the next edge, with no HiLoWrite and no Done; Count and DZ SHALL hold.
REQ-018 When Abort=1 and Start=1 arrive together in IDLE, Abort SHALL win and the request SHALL NOT be accepted.
REQ-019 Abort=1 in WRITE SHALL suppress HiLoWrite and Done in that cycle, so the flushed result is never written.
REQ-020 OpDiv SHALL remain stable from LOAD through WRITE.

Reset
REQ-021 When reset=1 at a clock edge, the FSM SHALL go to IDLE with Count=0, OpDiv=0, and DZ=0.
REQ-022 While in reset, Busy, Load, Step, HiLoWrite, Done, and Stall SHALL all be 0.
REQ-023 Reset SHALL take priority over Abort and Start.
REQ-024 Reset asserted mid-operation SHALL discard the operation with no HiLoWrite, and the unit SHALL accept a new Start on the first edge after reset falls.

Verification
REQ-025 MULTU issue: Start=1, Funct=6'b011001 at edge 0 -> Load high in cycle 1; Step high in cycles 2..33 with Count 0..31; HiLoWrite=Done=1 in cycle 34; Busy=0 from cycle 35.
REQ-026 DIVU with DivZero=1 in LOAD -> no Step pulses; HiLoWrite=Done=1 in cycle 2; DZ=1 until the next accepted Start.
REQ-027 MFLO presented during RUN (Count=10) and again in WRITE -> Stall=1 in both cycles; the same MFLO in the cycle after WRITE -> Stall=0.
REQ-028 Abort=1 at Count=5 -> IDLE next cycle; no HiLoWrite or Done ever for that operation; a following MULTU completes normally.
REQ-029 reset=1 for one cycle at Count=20 -> all outputs 0 in the next cycle; a Start in the first cycle after reset is accepted.
REQ-030 Start=1 with Funct=6'b100000 (ADD) in IDLE -> no state change and Stall=0; Start and Abort together in IDLE -> Busy remains 0.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Issue/status bundle between the pipeline and the multiply/divide sequencer.
interface muldiv_seq_if;
  logic       Start;
  logic [5:0] Funct;
  logic       DivZero;
  logic       Abort;
  logic       Busy;
  logic       Load;
  logic       Step;
  logic       OpDiv;
  logic       HiLoWrite;
  logic       Done;
  logic       DZ;
  logic       Stall;
  logic [5:0] Count;

  // Pipeline side: issues instructions and observes sequencer status.
  modport master (
    output Start, Funct, DivZero, Abort,
    input  Busy, Load, Step, OpDiv, HiLoWrite, Done, DZ, Stall, Count
  );

  // Sequencer side.
  modport slave (
    input  Start, Funct, DivZero, Abort,
    output Busy, Load, Step, OpDiv, HiLoWrite, Done, DZ, Stall, Count
  );
endinterface

// File: rtl/muldiv_seq.sv
// Control sequencer for an iterative MULTU/DIVU unit: LOAD, ITER steps, WRITE.
module muldiv_seq #(
  parameter int unsigned ITER  = 32,
  parameter logic [5:0]  MULTU = 6'b011001,
  parameter logic [5:0]  DIVU  = 6'b011011,
  parameter logic [5:0]  MFHI  = 6'b010000,
  parameter logic [5:0]  MFLO  = 6'b010010
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          op_div_q, op_div_d;
  logic          dz_q, dz_d;

  logic is_mdu_op;
  logic is_hilo_op;
  logic busy_c;
  logic load_c;
  logic step_c;
  logic hilo_write_c;
  logic done_c;
  logic stall_c;

  // State and operation context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_div_q <= op_div_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state, context update and status decode.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    op_div_d     = op_div_q;
    dz_d         = dz_q;
    is_mdu_op    = (bus.Funct == MULTU) || (bus.Funct == DIVU);
    is_hilo_op   = (bus.Funct == MFHI) || (bus.Funct == MFLO);
    busy_c       = 1'b0;
    load_c       = 1'b0;
    step_c       = 1'b0;
    hilo_write_c = 1'b0;
    done_c       = 1'b0;
    stall_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start && is_mdu_op) begin
          state_d  = S_LOAD;
          op_div_d = (bus.Funct == DIVU);
          count_d  = '0;
          dz_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (op_div_q && bus.DivZero) begin
          state_d = S_WRITE;
          dz_d    = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Count stops at ITER-1 so it never wraps inside an operation.
        if (count_q == LAST) begin
          state_d = S_WRITE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush discards the operation but leaves Count, DZ and OpDiv as they were.
    if (bus.Abort) begin
      state_d  = S_IDLE;
      count_d  = count_q;
      op_div_d = op_div_q;
      dz_d     = dz_q;
    end

    // Status outputs are forced low while reset is held.
    if (!reset) begin
      busy_c       = (state_q != S_IDLE);
      load_c       = (state_q == S_LOAD);
      step_c       = (state_q == S_RUN);
      hilo_write_c = (state_q == S_WRITE) && !bus.Abort;
      done_c       = (state_q == S_WRITE) && !bus.Abort;
      stall_c      = bus.Start && busy_c && (is_mdu_op || is_hilo_op);
    end
  end

  assign bus.Busy      = busy_c;
  assign bus.Load      = load_c;
  assign bus.Step      = step_c;
  assign bus.HiLoWrite = hilo_write_c;
  assign bus.Done      = done_c;
  assign bus.Stall     = stall_c;
  assign bus.OpDiv     = op_div_q;
  assign bus.DZ        = dz_q;
  assign bus.Count     = count_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected write-backs, a monitor pops them.
module tb_muldiv_seq;

  localparam int unsigned ITER    = 32;
  localparam logic [5:0]  F_MULTU = 6'b011001;
  localparam logic [5:0]  F_DIVU  = 6'b011011;
  localparam logic [5:0]  F_MFHI  = 6'b010000;
  localparam logic [5:0]  F_MFLO  = 6'b010010;
  localparam logic [5:0]  F_ADD   = 6'b100000;

  typedef struct {
    logic        op_div;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned acc;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  muldiv_seq_if bus ();

  muldiv_seq #(.ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Present one instruction for a single edge; acc records the accepting edge.
  task automatic issue(input logic [5:0] f);
    bus.Start = 1'b1;
    bus.Funct = f;
    tick();
    acc       = cyc;
    bus.Start = 1'b0;
    bus.Funct = 6'd0;
  endtask

  task automatic expect_write(input logic op_div, input logic dz, input int unsigned when);
    exp_t e;
    e.op_div = op_div;
    e.dz     = dz;
    e.cyc    = when;
    sb.push_back(e);
  endtask

  // Monitor: every observed write-back must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.HiLoWrite === 1'b1 || bus.Done === 1'b1) begin
      check("done_eq_hilowrite", 32'(bus.Done), 32'(bus.HiLoWrite));
    end
    if (bus.HiLoWrite === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(bus.HiLoWrite), 32'd0);
      end else begin
        e = sb.pop_front();
        check("write_cycle", cyc, e.cyc);
        check("write_opdiv", 32'(bus.OpDiv), 32'(e.op_div));
        check("write_dz", 32'(bus.DZ), 32'(e.dz));
      end
    end
  end

  initial begin
    bus.Start   = 1'b0;
    bus.Funct   = 6'd0;
    bus.DivZero = 1'b0;
    bus.Abort   = 1'b0;
    reset       = 1'b1;
    ticks(2);

    // Reset state, with a request presented that reset must override.
    bus.Start = 1'b1;
    bus.Funct = F_MULTU;
    #1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_stall", 32'(bus.Stall), 32'd0);
    check("rst_load", 32'(bus.Load), 32'd0);
    check("rst_step", 32'(bus.Step), 32'd0);
    check("rst_count", 32'(bus.Count), 32'd0);
    check("rst_opdiv", 32'(bus.OpDiv), 32'd0);
    check("rst_dz", 32'(bus.DZ), 32'd0);
    tick();
    bus.Start = 1'b0;
    check("rst_hold_busy", 32'(bus.Busy), 32'd0);
    reset = 1'b0;
    tick();

    // MULTU full walk.
    issue(F_MULTU);
    expect_write(1'b0, 1'b0, acc + ITER + 1);
    check("mul_load", 32'(bus.Load), 32'd1);
    check("mul_busy_load", 32'(bus.Busy), 32'd1);
    check("mul_nostep_load", 32'(bus.Step), 32'd0);
    for (int i = 0; i < int'(ITER); i++) begin
      tick();
      check("mul_step", 32'(bus.Step), 32'd1);
      check("mul_count", 32'(bus.Count), 32'(i));
    end
    tick();
    check("mul_write", 32'(bus.HiLoWrite), 32'd1);
    check("mul_nostep_write", 32'(bus.Step), 32'd0);
    check("mul_busy_write", 32'(bus.Busy), 32'd1);
    tick();
    check("mul_idle", 32'(bus.Busy), 32'd0);

    // DIVU with zero divisor bypasses RUN.
    issue(F_DIVU);
    bus.DivZero = 1'b1;
    expect_write(1'b1, 1'b1, acc + 1);
    check("dz_load", 32'(bus.Load), 32'd1);
    check("dz_opdiv", 32'(bus.OpDiv), 32'd1);
    tick();
    bus.DivZero = 1'b0;
    check("dz_nostep", 32'(bus.Step), 32'd0);
    check("dz_write", 32'(bus.HiLoWrite), 32'd1);
    tick();
    check("dz_idle", 32'(bus.Busy), 32'd0);
    ticks(3);
    check("dz_hold", 32'(bus.DZ), 32'd1);

    // DIVU normal, with stall probes during RUN and WRITE.
    issue(F_DIVU);
    expect_write(1'b1, 1'b0, acc + ITER + 1);
    check("div_dz_cleared", 32'(bus.DZ), 32'd0);
    ticks(11);
    check("div_count10", 32'(bus.Count), 32'd10);
    bus.Start = 1'b1;
    bus.Funct = F_MFLO;
    #1;
    check("stall_mflo_run", 32'(bus.Stall), 32'd1);
    bus.Funct = F_MFHI;
    #1;
    check("stall_mfhi_run", 32'(bus.Stall), 32'd1);
    bus.Funct = F_ADD;
    #1;
    check("stall_add_run", 32'(bus.Stall), 32'd0);
    bus.Funct = F_DIVU;
    #1;
    check("stall_divu_run", 32'(bus.Stall), 32'd1);
    tick();
    bus.Start = 1'b0;
    check("div_count11", 32'(bus.Count), 32'd11);
    ticks(int'(ITER) - 12);
    check("div_opdiv_run", 32'(bus.OpDiv), 32'd1);
    tick();
    check("div_write", 32'(bus.HiLoWrite), 32'd1);
    bus.Start = 1'b1;
    bus.Funct = F_MFLO;
    #1;
    check("stall_mflo_write", 32'(bus.Stall), 32'd1);
    tick();
    check("stall_mflo_idle", 32'(bus.Stall), 32'd0);
    check("div_idle", 32'(bus.Busy), 32'd0);
    tick();
    check("mflo_no_accept", 32'(bus.Busy), 32'd0);
    bus.Start = 1'b0;

    // Abort at Count=5, then a clean MULTU.
    issue(F_MULTU);
    ticks(6);
    check("abort_count5", 32'(bus.Count), 32'd5);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    check("abort_idle", 32'(bus.Busy), 32'd0);
    check("abort_count_hold", 32'(bus.Count), 32'd5);
    ticks(int'(ITER) + 4);
    issue(F_MULTU);
    expect_write(1'b0, 1'b0, acc + ITER + 1);
    ticks(int'(ITER) + 2);
    check("post_abort_idle", 32'(bus.Busy), 32'd0);

    // Abort landing in WRITE suppresses the write-back.
    issue(F_MULTU);
    ticks(int'(ITER) + 1);
    check("abw_busy", 32'(bus.Busy), 32'd1);
    bus.Abort = 1'b1;
    #1;
    check("abw_no_write", 32'(bus.HiLoWrite), 32'd0);
    check("abw_no_done", 32'(bus.Done), 32'd0);
    tick();
    bus.Abort = 1'b0;
    check("abw_idle", 32'(bus.Busy), 32'd0);

    // Reset clears a sticky DZ.
    issue(F_DIVU);
    bus.DivZero = 1'b1;
    expect_write(1'b1, 1'b1, acc + 1);
    tick();
    bus.DivZero = 1'b0;
    tick();
    check("pre_rst_dz", 32'(bus.DZ), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_dz_clear", 32'(bus.DZ), 32'd0);
    check("rst_opdiv_clear", 32'(bus.OpDiv), 32'd0);

    // Reset mid-operation at Count=20, restart on the first edge afterwards.
    issue(F_MULTU);
    ticks(21);
    check("rst_mid_count20", 32'(bus.Count), 32'd20);
    reset     = 1'b1;
    bus.Start = 1'b1;
    bus.Funct = F_MULTU;
    #1;
    check("rst_mid_busy", 32'(bus.Busy), 32'd0);
    check("rst_mid_step", 32'(bus.Step), 32'd0);
    check("rst_mid_stall", 32'(bus.Stall), 32'd0);
    tick();
    reset = 1'b0;
    check("rst_mid_count0", 32'(bus.Count), 32'd0);
    check("rst_mid_idle", 32'(bus.Busy), 32'd0);
    tick();
    acc = cyc;
    bus.Start = 1'b0;
    expect_write(1'b0, 1'b0, acc + ITER + 1);
    check("restart_load", 32'(bus.Load), 32'd1);
    ticks(int'(ITER) + 2);
    check("restart_done_idle", 32'(bus.Busy), 32'd0);

    // Non-MDU funct and Start+Abort in IDLE are ignored.
    bus.Start = 1'b1;
    bus.Funct = F_ADD;
    #1;
    check("add_stall", 32'(bus.Stall), 32'd0);
    tick();
    check("add_idle", 32'(bus.Busy), 32'd0);
    bus.Funct = F_MULTU;
    bus.Abort = 1'b1;
    tick();
    check("start_abort_idle", 32'(bus.Busy), 32'd0);
    check("start_abort_noload", 32'(bus.Load), 32'd0);
    bus.Start = 1'b0;
    bus.Abort = 1'b0;

    ticks(5);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
